// File: rtl/count8_ctrl.sv
// Sequencing controller that turns an external 8-bit loadable up-counter into
// a one-shot / periodic interval timer with terminal-count pulse and pulse count.
module count8_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Res,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             periodic,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] cnt_val,
    output logic             cnt_en,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_load_val,
    output logic             busy,
    output logic             done,
    output logic             tc,
    output logic [WIDTH-1:0] tc_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] tcCount_q, tcCount_d;

    logic match;
    logic quiet;
    logic tcFire;

    // stop and start both own the cycle they appear in, so normal RUN activity is muted
    assign match  = (cnt_val == period_q);
    assign quiet  = stop | start;
    assign tcFire = (state_q == RUN) && !quiet && !pause && match;

    always_ff @(posedge Clk) begin
        if (Res) begin
            state_q   <= IDLE;
            period_q  <= '0;
            mode_q    <= 1'b0;
            tcCount_q <= '0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            mode_q    <= mode_d;
            tcCount_q <= tcCount_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        mode_d    = mode_q;
        tcCount_d = tcCount_q;
        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            period_d  = period;
            mode_d    = periodic;
            tcCount_d = '0;
            state_d   = LOAD;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                LOAD: state_d = RUN;
                RUN: begin
                    if (tcFire) begin
                        tcCount_d = tcCount_q + WIDTH'(1);
                        if (!mode_q) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // A periodic match reloads instead of counting, so enable and load stay exclusive
    always_comb begin
        cnt_en       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        tc           = 1'b0;
        busy         = (state_q == LOAD) || (state_q == RUN);
        done         = (state_q == DONE);
        tc_count     = tcCount_q;
        if (!quiet) begin
            case (state_q)
                LOAD: cnt_load = 1'b1;
                RUN: begin
                    if (!pause) begin
                        if (match) begin
                            tc       = 1'b1;
                            cnt_load = mode_q;
                        end else begin
                            cnt_en = 1'b1;
                        end
                    end
                end
                default: begin
                    cnt_en   = 1'b0;
                    cnt_load = 1'b0;
                end
            endcase
        end
    end

endmodule
